ifft8_engine: RTL

Eight-point complex inverse FFT engine: the return path for the forward radix-2 butterfly datapath. It accepts eight frequency-domain samples over a valid/ready stream and computes the IDFT in place with one time-multiplexed conjugate-twiddle butterfly. It then streams eight time-domain samples out in natural order. Each stage scales by 1/2, so the result carries the IDFT 1/N factor with no separate divide.

---
 rtl/fft_pkg.sv | 31 +++
 rtl/ifft_butterfly_unit.sv | 86 ++++++++
 rtl/ifft8_engine.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fft_pkg
// Shared widths, twiddle scaling, sample/state types and address helper.
// Rev     : 1.0
// ============================================================================
package fft_pkg;

    localparam int W        = 12;
    localparam int N        = 8;
    localparam int LOG2N    = 3;
    localparam int TW_SCALE = 181;   // round(256/sqrt(2))
    localparam int TW_SHIFT = 8;

    typedef struct packed {
        logic signed [W-1:0] re;
        logic signed [W-1:0] im;
    } cplx_t;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_CALC = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    function automatic logic [LOG2N-1:0] bitrev3(input logic [LOG2N-1:0] a);
        return {a[0], a[1], a[2]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ifft_butterfly_unit.sv
`default_nettype none
// ============================================================================
// Module  : ifft_butterfly_unit
// Registered radix-2 butterfly with conjugate W8 twiddles and 1/2 scaling.
// Rev     : 1.0
// ============================================================================
module ifft_butterfly_unit #(
    parameter int W = 12
) (
    input  logic                clk,
    input  logic                en,
    input  logic [1:0]          k,
    input  logic signed [W-1:0] x0_re,
    input  logic signed [W-1:0] x0_im,
    input  logic signed [W-1:0] x1_re,
    input  logic signed [W-1:0] x1_im,
    output logic signed [W-1:0] a0_re,
    output logic signed [W-1:0] a0_im,
    output logic signed [W-1:0] a1_re,
    output logic signed [W-1:0] a1_im
);

    import fft_pkg::TW_SCALE;
    import fft_pkg::TW_SHIFT;

    localparam int PW = W + 1 + TW_SHIFT;
    localparam logic signed [PW-1:0] c_tw = PW'(TW_SCALE);

    logic signed [W:0]    w_x1r, w_x1i, w_x0r, w_x0i;
    logic signed [W:0]    w_sum, w_dif, w_nsum;
    logic signed [PW-1:0] w_sum_x, w_dif_x, w_nsum_x;
    logic signed [PW-1:0] w_p_sum, w_p_dif, w_p_nsum;
    logic signed [W:0]    w_yr, w_yi;

    assign w_x1r = {x1_re[W-1], x1_re};
    assign w_x1i = {x1_im[W-1], x1_im};
    assign w_x0r = {x0_re[W-1], x0_re};
    assign w_x0i = {x0_im[W-1], x0_im};

    assign w_sum  = w_x1r + w_x1i;
    assign w_dif  = w_x1r - w_x1i;
    assign w_nsum = -w_x1r - w_x1i;

    assign w_sum_x  = {{TW_SHIFT{w_sum[W]}},  w_sum};
    assign w_dif_x  = {{TW_SHIFT{w_dif[W]}},  w_dif};
    assign w_nsum_x = {{TW_SHIFT{w_nsum[W]}}, w_nsum};

    assign w_p_sum  = w_sum_x  * c_tw;
    assign w_p_dif  = w_dif_x  * c_tw;
    assign w_p_nsum = w_nsum_x * c_tw;

    always_comb begin
        w_yr = w_x1r;
        w_yi = w_x1i;
        case (k)
            2'd1: begin
                w_yr = (W+1)'(w_p_dif >>> TW_SHIFT);
                w_yi = (W+1)'(w_p_sum >>> TW_SHIFT);
            end
            2'd2: begin
                w_yr = -w_x1i;
                w_yi = w_x1r;
            end
            2'd3: begin
                w_yr = (W+1)'(w_p_nsum >>> TW_SHIFT);
                w_yi = (W+1)'(w_p_dif  >>> TW_SHIFT);
            end
            default: begin
                w_yr = w_x1r;
                w_yi = w_x1i;
            end
        endcase
    end

    // Sums wrap at W+1 bits; the input bound keeps them in range.
    always_ff @(posedge clk) begin
        if (en) begin
            a0_re <= W'((w_x0r + w_yr) >>> 1);
            a0_im <= W'((w_x0i + w_yi) >>> 1);
            a1_re <= W'((w_x0r - w_yr) >>> 1);
            a1_im <= W'((w_x0i - w_yi) >>> 1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/ifft8_engine.sv
`default_nettype none
// ============================================================================
// Module  : ifft8_engine
// 8-point in-place inverse FFT: load bit-reversed, 3 scaled stages, stream out.
// Rev     : 1.0
// ============================================================================
module ifft8_engine #(
    parameter int W = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] in_re,
    input  logic signed [W-1:0] in_im,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [W-1:0] out_re,
    output logic signed [W-1:0] out_im,
    output logic                out_last,
    output logic                busy
);

    import fft_pkg::N;
    import fft_pkg::LOG2N;
    import fft_pkg::state_t;
    import fft_pkg::ST_LOAD;
    import fft_pkg::ST_CALC;
    import fft_pkg::ST_OUT;
    import fft_pkg::bitrev3;

    state_t             r_state;
    logic [LOG2N-1:0]   r_cnt;
    logic [1:0]         r_stage;
    logic [1:0]         r_bf;
    logic               r_wr;

    logic signed [W-1:0] r_mem_re [N];
    logic signed [W-1:0] r_mem_im [N];

    logic [LOG2N-1:0]    w_lo, w_hi;
    logic [1:0]          w_k;
    logic                w_in_fire, w_out_fire, w_bf_en, w_bf_wr;
    logic signed [W-1:0] w_a0_re, w_a0_im, w_a1_re, w_a1_im;

    assign w_in_fire  = in_valid  && (r_state == ST_LOAD);
    assign w_out_fire = out_ready && (r_state == ST_OUT);
    assign w_bf_en    = (r_state == ST_CALC) && !r_wr;
    assign w_bf_wr    = (r_state == ST_CALC) &&  r_wr;

    // Pair addresses and twiddle index for butterfly r_bf of stage r_stage.
    always_comb begin
        w_lo = {1'b0, r_bf};
        w_hi = {1'b1, r_bf};
        w_k  = r_bf;
        case (r_stage)
            2'd0: begin
                w_lo = {r_bf, 1'b0};
                w_hi = {r_bf, 1'b1};
                w_k  = 2'd0;
            end
            2'd1: begin
                w_lo = {r_bf[1], 1'b0, r_bf[0]};
                w_hi = {r_bf[1], 1'b1, r_bf[0]};
                w_k  = {r_bf[0], 1'b0};
            end
            default: begin
                w_lo = {1'b0, r_bf};
                w_hi = {1'b1, r_bf};
                w_k  = r_bf;
            end
        endcase
    end

    ifft_butterfly_unit #(
        .W (W)
    ) u_bfly (
        .clk   (clk),
        .en    (w_bf_en),
        .k     (w_k),
        .x0_re (r_mem_re[w_lo]),
        .x0_im (r_mem_im[w_lo]),
        .x1_re (r_mem_re[w_hi]),
        .x1_im (r_mem_im[w_hi]),
        .a0_re (w_a0_re),
        .a0_im (w_a0_im),
        .a1_re (w_a1_re),
        .a1_im (w_a1_im)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_LOAD;
            r_cnt   <= '0;
            r_stage <= 2'd0;
            r_bf    <= 2'd0;
            r_wr    <= 1'b0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (w_in_fire) begin
                        r_cnt <= r_cnt + 3'd1;
                        if (r_cnt == 3'(N-1)) begin
                            r_cnt   <= '0;
                            r_state <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    r_wr <= ~r_wr;
                    if (r_wr) begin
                        r_bf <= r_bf + 2'd1;
                        if (r_bf == 2'd3) begin
                            if (r_stage == 2'd2) begin
                                r_stage <= 2'd0;
                                r_state <= ST_OUT;
                            end else begin
                                r_stage <= r_stage + 2'd1;
                            end
                        end
                    end
                end
                ST_OUT: begin
                    if (w_out_fire) begin
                        r_cnt <= r_cnt + 3'd1;
                        if (r_cnt == 3'(N-1)) begin
                            r_cnt   <= '0;
                            r_state <= ST_LOAD;
                        end
                    end
                end
                default: begin
                    r_state <= ST_LOAD;
                    r_cnt   <= '0;
                    r_stage <= 2'd0;
                    r_bf    <= 2'd0;
                    r_wr    <= 1'b0;
                end
            endcase
        end
    end

    // Sample storage carries no reset; its contents are rewritten every frame.
    always_ff @(posedge clk) begin
        if (w_in_fire) begin
            r_mem_re[bitrev3(r_cnt)] <= in_re;
            r_mem_im[bitrev3(r_cnt)] <= in_im;
        end else if (w_bf_wr) begin
            r_mem_re[w_lo] <= w_a0_re;
            r_mem_im[w_lo] <= w_a0_im;
            r_mem_re[w_hi] <= w_a1_re;
            r_mem_im[w_hi] <= w_a1_im;
        end
    end

    assign in_ready  = (r_state == ST_LOAD);
    assign busy      = (r_state != ST_LOAD);
    assign out_valid = (r_state == ST_OUT);
    assign out_last  = out_valid && (r_cnt == 3'(N-1));
    assign out_re    = out_valid ? r_mem_re[r_cnt] : '0;
    assign out_im    = out_valid ? r_mem_im[r_cnt] : '0;

endmodule
`default_nettype wire
